// File: rtl/ad9361_spi_arbiter_pkg.sv
// Shared encodings and widths for the AD9361 SPI register arbiter.
package ad9361_spi_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int GID_W  = 3;

    // 2 ms at 20 MHz
    localparam logic [25:0] DEFAULT_TIMEOUT = 26'd40000;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_GRANT = 5'b00010,
        ST_ISSUE = 5'b00100,
        ST_WAIT  = 5'b01000,
        ST_DONE  = 5'b10000
    } state_e;

endpackage

// File: rtl/ad9361_spi_arbiter_rr_arbiter.sv
// Combinational round-robin picker: rotate requests so the pointer is bit 0,
// take the lowest set bit, then rotate the winner index back.
module rr_arbiter
    import ad9361_spi_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [GID_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [GID_W-1:0]   idx_o
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [3:0]           sum;

    always_comb begin
        dbl = {req_i, req_i} >> ptr_i;
        rot = dbl[NUM_REQ-1:0];
        sum = 4'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) sum = 4'(i);
        end
        sum = sum + {1'b0, ptr_i};
        if (sum >= 4'(NUM_REQ)) sum = sum - 4'(NUM_REQ);
        idx_o = sum[GID_W-1:0];
        gnt_o = (|req_i) ? (NUM_REQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/ad9361_spi_arbiter.sv
// Round-robin arbiter sharing one AD9361 SPI register driver between NUM_REQ
// requesters; port 0 can be made exclusive with lock0 during boot config.
module ad9361_spi_arbiter
    import ad9361_spi_pkg::*;
#(
    parameter int          NUM_REQ = 4,
    parameter logic [25:0] TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      lock0,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_wr_rdn,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic                      rsp_err,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         drv_addr,
    output logic [DATA_W-1:0]         drv_wdata,
    output logic                      drv_en,
    output logic                      drv_wr_rdn,
    input  logic                      drv_busy,
    input  logic [DATA_W-1:0]         drv_rdata,
    input  logic                      drv_rdata_en,
    output logic [GID_W-1:0]          grant_id
);

    state_e               state_q;
    logic [GID_W-1:0]     ptr_q, gid_q;
    logic [NUM_REQ-1:0]   own_q, req_ready_q, rsp_valid_q;
    logic                 wr_q, got_q, drv_en_q, rsp_err_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q, rdata_q, rsp_rdata_q;
    logic [25:0]          cnt_q, cnt_d;
    logic                 timeout_hit;

    logic [NUM_REQ-1:0]   elig, pick_gnt;
    logic [GID_W-1:0]     pick_idx;
    logic                 sel_wr;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;

    assign elig = req_valid & (lock0 ? NUM_REQ'(1) : {NUM_REQ{1'b1}});

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i (elig),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                sel_wr    = req_wr_rdn[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Abort on the cycle in which the phase count would reach TIMEOUT.
    assign cnt_d       = cnt_q + 26'd1;
    assign timeout_hit = (cnt_d == TIMEOUT);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gid_q       <= '0;
            own_q       <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            got_q       <= 1'b0;
            drv_en_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if ((|elig) && !drv_busy) begin
                        state_q     <= ST_GRANT;
                        req_ready_q <= pick_gnt;
                        own_q       <= pick_gnt;
                        gid_q       <= pick_idx;
                        wr_q        <= sel_wr;
                        addr_q      <= sel_addr;
                        wdata_q     <= sel_wdata;
                        ptr_q       <= (pick_idx == GID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    end
                end
                ST_GRANT: begin
                    state_q  <= ST_ISSUE;
                    drv_en_q <= 1'b1;
                    cnt_q    <= '0;
                end
                ST_ISSUE: begin
                    if (drv_busy) begin
                        state_q  <= ST_WAIT;
                        drv_en_q <= 1'b0;
                        cnt_q    <= '0;
                    end else if (timeout_hit) begin
                        state_q     <= ST_DONE;
                        drv_en_q    <= 1'b0;
                        rsp_valid_q <= own_q;
                        rsp_err_q   <= 1'b1;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_WAIT: begin
                    if (drv_rdata_en && !wr_q) begin
                        rdata_q <= drv_rdata;
                        got_q   <= 1'b1;
                    end
                    // Read data arriving together with the busy fall still completes.
                    if (!drv_busy && (wr_q || got_q || drv_rdata_en)) begin
                        state_q     <= ST_DONE;
                        rsp_valid_q <= own_q;
                        rsp_rdata_q <= wr_q ? '0 : (drv_rdata_en ? drv_rdata : rdata_q);
                        cnt_q       <= '0;
                    end else if (timeout_hit) begin
                        state_q     <= ST_DONE;
                        rsp_valid_q <= own_q;
                        rsp_err_q   <= 1'b1;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    got_q   <= 1'b0;
                    cnt_q   <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign drv_addr   = addr_q;
    assign drv_wdata  = wdata_q;
    assign drv_en     = drv_en_q;
    assign drv_wr_rdn = wr_q;
    assign grant_id   = gid_q;

endmodule

// File: tb/tb_ad9361_spi_arbiter.sv
// Bench for ad9361_spi_arbiter: behavioural SPI driver model plus scoreboard
// queues for grants, driver issues and responses.
module tb_ad9361_spi_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           lock0 = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_wr_rdn = '0;
    logic [N*10-1:0] req_addr = '0;
    logic [N*8-1:0] req_wdata = '0;
    logic [N-1:0]   req_ready, rsp_valid;
    logic           rsp_err;
    logic [7:0]     rsp_rdata;
    logic [9:0]     drv_addr;
    logic [7:0]     drv_wdata;
    logic           drv_en, drv_wr_rdn;
    logic           drv_busy;
    logic [7:0]     drv_rdata;
    logic           drv_rdata_en;
    logic [2:0]     grant_id;

    int mode = 0;              // 0 normal, 1 never busy, 2 rdata_en with busy fall
    logic [7:0] model_val = 8'h00;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         id;
        bit         wr;
        logic [9:0] addr;
        logic [7:0] wdata;
        bit         err;
        logic [7:0] rdata;
    } exp_t;

    typedef struct {
        int         id;
        bit         wr;
        logic [9:0] addr;
        logic [7:0] wdata;
        logic [7:0] val;
        logic [7:0] exp_rdata;
    } vec_t;

    exp_t gq[$];
    exp_t iq[$];
    exp_t rq[$];

    ad9361_spi_arbiter #(.NUM_REQ(N), .TIMEOUT(26'd100)) dut (
        .sys_clk      (clk),
        .sys_rst_n    (rst_n),
        .lock0        (lock0),
        .req_valid    (req_valid),
        .req_wr_rdn   (req_wr_rdn),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .drv_addr     (drv_addr),
        .drv_wdata    (drv_wdata),
        .drv_en       (drv_en),
        .drv_wr_rdn   (drv_wr_rdn),
        .drv_busy     (drv_busy),
        .drv_rdata    (drv_rdata),
        .drv_rdata_en (drv_rdata_en),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver model: busy 3 cycles after en, 40 busy cycles, rdata_en before (or with) busy fall.
    initial begin : drv_model
        int m_cnt;
        bit m_act;
        bit m_wr;
        m_cnt = 0; m_act = 0; m_wr = 0;
        drv_busy = 1'b0; drv_rdata = 8'h00; drv_rdata_en = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_act = 0; drv_busy = 1'b0; drv_rdata_en = 1'b0;
            end else if (!m_act) begin
                drv_rdata_en = 1'b0;
                if (drv_en && mode != 1) begin
                    m_act = 1; m_cnt = 0; m_wr = drv_wr_rdn;
                end
            end else begin
                m_cnt++;
                if (m_cnt == 3) drv_busy = 1'b1;
                if (m_cnt == 42 && !m_wr && mode == 0) begin
                    drv_rdata_en = 1'b1; drv_rdata = model_val;
                end
                if (m_cnt == 43) begin
                    drv_busy = 1'b0;
                    drv_rdata_en = (!m_wr && mode == 2);
                    if (!m_wr && mode == 2) drv_rdata = model_val;
                end
                if (m_cnt == 44) begin
                    drv_rdata_en = 1'b0; m_act = 0;
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        bit prev_en;
        prev_en = 0;
        forever begin
            @(negedge clk);
            if (req_ready != '0) begin
                if (gq.size() == 0) chk("unexpected_grant", 32'(req_ready), 0);
                else begin
                    e = gq.pop_front();
                    chk("grant_onehot", 32'(req_ready), 32'(1) << e.id);
                    chk("grant_id", 32'(grant_id), 32'(e.id));
                end
            end
            if (drv_en && !prev_en) begin
                if (iq.size() == 0) chk("unexpected_issue", 32'(drv_en), 0);
                else begin
                    e = iq.pop_front();
                    chk("drv_addr", 32'(drv_addr), 32'(e.addr));
                    chk("drv_wdata", 32'(drv_wdata), 32'(e.wdata));
                    chk("drv_wr_rdn", 32'(drv_wr_rdn), 32'(e.wr));
                end
            end
            prev_en = drv_en;
            if (rsp_valid != '0) begin
                if (rq.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 0);
                else begin
                    e = rq.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        req_valid = req_valid & ~req_ready;
    endtask

    task automatic drive_req(input int id, input bit wr, input logic [9:0] a, input logic [7:0] d);
        req_wr_rdn[id]       = wr;
        req_addr[id*10 +: 10] = a;
        req_wdata[id*8 +: 8]  = d;
        req_valid[id]        = 1'b1;
    endtask

    task automatic expect_txn(input int id, input bit wr, input logic [9:0] a, input logic [7:0] d,
                              input bit err, input logic [7:0] rd);
        exp_t e;
        e = '{id, wr, a, d, err, rd};
        gq.push_back(e);
        iq.push_back(e);
        rq.push_back(e);
    endtask

    task automatic wait_rsp(input int budget);
        int n = 0;
        while (rq.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("rsp_drain_bound", 32'(rq.size()), 0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((rq.size() != 0 || req_valid != '0) && n < budget) begin
            tick();
            n++;
        end
        chk("idle_bound", 32'(rq.size()) + 32'(req_valid), 0);
        repeat (3) tick();
    endtask

    initial begin : main
        vec_t tbl[6];
        int n;

        tbl[0] = '{2, 1'b1, 10'h3FF, 8'hFF, 8'h00, 8'h00};
        tbl[1] = '{3, 1'b0, 10'h000, 8'h00, 8'hFF, 8'hFF};
        tbl[2] = '{0, 1'b0, 10'h155, 8'h00, 8'h00, 8'h00};
        tbl[3] = '{1, 1'b1, 10'h2AA, 8'h5A, 8'h77, 8'h00};
        tbl[4] = '{0, 1'b1, 10'h001, 8'h80, 8'h00, 8'h00};
        tbl[5] = '{2, 1'b0, 10'h123, 8'h00, 8'h3C, 8'h3C};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_drv_en", 32'(drv_en), 0);
        chk("rst_drv_addr", 32'(drv_addr), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_drv_en", 32'(drv_en), 0);

        // Round robin from pointer 0, then wrap back to requester 0
        model_val = 8'h3C;
        drive_req(0, 1'b0, 10'h010, 8'h00);
        drive_req(1, 1'b1, 10'h011, 8'h11);
        drive_req(2, 1'b0, 10'h012, 8'h00);
        drive_req(3, 1'b1, 10'h013, 8'h33);
        expect_txn(0, 1'b0, 10'h010, 8'h00, 1'b0, 8'h3C);
        expect_txn(1, 1'b1, 10'h011, 8'h11, 1'b0, 8'h00);
        expect_txn(2, 1'b0, 10'h012, 8'h00, 1'b0, 8'h3C);
        expect_txn(3, 1'b1, 10'h013, 8'h33, 1'b0, 8'h00);
        wait_idle(1000);
        drive_req(3, 1'b1, 10'h023, 8'h44);
        drive_req(0, 1'b1, 10'h020, 8'h55);
        expect_txn(0, 1'b1, 10'h020, 8'h55, 1'b0, 8'h00);
        expect_txn(3, 1'b1, 10'h023, 8'h44, 1'b0, 8'h00);
        wait_idle(500);

        // Single read on requester 1 with latency checks
        model_val = 8'h08;
        drive_req(1, 1'b0, 10'h037, 8'h00);
        expect_txn(1, 1'b0, 10'h037, 8'h00, 1'b0, 8'h08);
        tick();
        chk("rd1_ready_pulse", 32'(req_ready), 32'h2);
        chk("rd1_en_not_yet", 32'(drv_en), 0);
        tick();
        chk("rd1_ready_gone", 32'(req_ready), 0);
        chk("rd1_en_latency", 32'(drv_en), 1);
        wait_idle(300);

        // Table of single transactions
        for (int i = 0; i < 6; i++) begin
            model_val = tbl[i].val;
            drive_req(tbl[i].id, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
            expect_txn(tbl[i].id, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b0, tbl[i].exp_rdata);
            wait_idle(300);
        end

        // lock0: only requester 0 while locked
        model_val = 8'h6B;
        lock0 = 1'b1;
        drive_req(1, 1'b0, 10'h101, 8'h00);
        drive_req(2, 1'b1, 10'h102, 8'hC2);
        drive_req(0, 1'b0, 10'h100, 8'h00);
        expect_txn(0, 1'b0, 10'h100, 8'h00, 1'b0, 8'h6B);
        wait_rsp(300);
        repeat (30) tick();
        chk("lock_pending", 32'(req_valid), 32'h6);
        expect_txn(1, 1'b0, 10'h101, 8'h00, 1'b0, 8'h6B);
        expect_txn(2, 1'b1, 10'h102, 8'hC2, 1'b0, 8'h00);
        lock0 = 1'b0;
        wait_idle(500);

        // Timeout: driver never goes busy
        mode = 1;
        drive_req(3, 1'b0, 10'h0AB, 8'h00);
        expect_txn(3, 1'b0, 10'h0AB, 8'h00, 1'b1, 8'h00);
        n = 0;
        while (!drv_en && n < 10) begin tick(); n++; end
        chk("to_issue_seen", 32'(drv_en), 1);
        n = 0;
        while (rsp_valid == '0 && n < 300) begin tick(); n++; end
        chk("to_cycles", 32'(n), 100);
        chk("to_drv_en_low", 32'(drv_en), 0);
        mode = 0;
        wait_idle(50);
        model_val = 8'h42;
        drive_req(1, 1'b0, 10'h010, 8'h00);
        expect_txn(1, 1'b0, 10'h010, 8'h00, 1'b0, 8'h42);
        wait_idle(300);

        // Read data coincident with busy fall
        mode = 2;
        model_val = 8'hA5;
        drive_req(0, 1'b0, 10'h3A5, 8'h00);
        expect_txn(0, 1'b0, 10'h3A5, 8'h00, 1'b0, 8'hA5);
        wait_idle(300);
        mode = 0;

        // Async reset while waiting on the driver
        model_val = 8'h11;
        drive_req(2, 1'b0, 10'h044, 8'h00);
        expect_txn(2, 1'b0, 10'h044, 8'h00, 1'b0, 8'h11);
        n = 0;
        while (!drv_busy && n < 20) begin tick(); n++; end
        chk("rst_wait_busy", 32'(drv_busy), 1);
        repeat (5) tick();
        drive_req(3, 1'b1, 10'h2F0, 8'h9E);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        rq.delete();
        chk("arst_drv_en", 32'(drv_en), 0);
        chk("arst_rsp_valid", 32'(rsp_valid), 0);
        chk("arst_grant_id", 32'(grant_id), 0);
        chk("arst_drv_addr", 32'(drv_addr), 0);
        repeat (2) tick();
        expect_txn(3, 1'b1, 10'h2F0, 8'h9E, 1'b0, 8'h00);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(req_ready), 32'h8);
        tick();
        chk("post_rst_en", 32'(drv_en), 1);
        wait_idle(300);

        chk("queues_empty", 32'(gq.size() + iq.size() + rq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
